// File: rtl/riscv_defs.sv
// Shared core definitions: canonical NOP encoding and program-loader state encoding.
package riscv_defs;

  localparam logic [31:0] INS_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; strobes on the 4th byte
// or on the last byte, with lanes not yet received forced to zero.
module byte_word_packer
  import riscv_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  data,
  input  logic        last,
  output logic [31:0] word,
  output logic        word_strobe
);

  logic [1:0]  byte_idx;
  logic [23:0] asm_q;

  // Only lanes below byte_idx hold bytes of the current word; stale upper
  // lanes from a previous word must not leak into a short final word.
  always_comb begin
    word = '0;
    unique case (byte_idx)
      2'd0:    word = {24'h0, data};
      2'd1:    word = {16'h0, data, asm_q[7:0]};
      2'd2:    word = {8'h0, data, asm_q[15:0]};
      default: word = {data, asm_q};
    endcase
  end

  assign word_strobe = take & (last | (byte_idx == 2'd3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= '0;
      asm_q    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (take) begin
      if (word_strobe) begin
        byte_idx <= '0;
      end else begin
        byte_idx <= byte_idx + 2'd1;
        unique case (byte_idx)
          2'd0:    asm_q[7:0]   <= data;
          2'd1:    asm_q[15:8]  <= data;
          default: asm_q[23:16] <= data;
        endcase
      end
    end
  end

endmodule

// File: rtl/inst_rom.sv
// Instruction memory with zero-cycle fetch read and a valid/ready byte-stream
// program loader that fills the array word by word.
module inst_rom
  import riscv_defs::*;
#(
  parameter int DEPTH     = 4096,
  parameter int ADDR_W    = 12,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc2rom,
  output logic [31:0]       rom_ins,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
);

  logic [31:0] mem [DEPTH];

  ld_state_t state, state_nxt;

  logic        full, accept, take, ovf;
  logic [31:0] word;
  logic        word_strobe;

  assign full   = (word_cnt == (ADDR_W+1)'(DEPTH));
  // ld_start wins over a coincident byte, which is dropped
  assign accept = ld_valid & ld_ready & ~ld_start;
  assign take   = accept & ~full;
  assign ovf    = accept & full;

  byte_word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear       (ld_start),
    .take        (take),
    .data        (ld_byte),
    .last        (ld_last),
    .word        (word),
    .word_strobe (word_strobe)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (ld_start) begin
      state_nxt = ST_LOAD;
    end else if (state == ST_LOAD) begin
      if (ovf | (take & ld_last)) state_nxt = ST_DONE;
    end
  end

  always_comb begin
    ld_ready  = (state == ST_LOAD);
    load_busy = (state == ST_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt  <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else if (ld_start) begin
      word_cnt  <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      if (ovf) begin
        load_err  <= 1'b1;
        load_done <= 1'b1;
      end else if (take & ld_last) begin
        load_done <= 1'b1;
      end
      if (word_strobe) word_cnt <= word_cnt + 1'b1;
    end
  end

  // word_strobe implies !full, so the index is always below DEPTH
  always_ff @(posedge clk) begin
    if (word_strobe) mem[word_cnt[ADDR_W-1:0]] <= word;
  end

  always_comb begin
    rom_ins = INS_NOP;
    if (!load_busy && pc2rom[1:0] == 2'b00 &&
        pc2rom[31:ADDR_W+2] == '0)
      rom_ins = mem[pc2rom[ADDR_W+1:2]];
  end

endmodule

// File: tb/tb_inst_rom.sv
// Directed bench for inst_rom with a small array; expected fetch words are
// queued as bytes are sent and popped when the word is read back.
module tb_inst_rom;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       pc2rom;
  logic [31:0]       rom_ins;
  logic              ld_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [7:0]        ld_byte;
  logic              ld_last;
  logic              load_busy;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   word_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  inst_rom #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_FILE("")) dut (
    .clk       (clk),
    .rst       (rst),
    .pc2rom    (pc2rom),
    .rom_ins   (rom_ins),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_byte   (ld_byte),
    .ld_last   (ld_last),
    .load_busy (load_busy),
    .load_done (load_done),
    .load_err  (load_err),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic status(input string tag, input logic busy,
                        input logic done, input logic err,
                        input int wc);
    chk({tag, ".busy"}, 32'(load_busy), 32'(busy));
    chk({tag, ".ready"}, 32'(ld_ready), 32'(busy));
    chk({tag, ".done"}, 32'(load_done), 32'(done));
    chk({tag, ".err"}, 32'(load_err), 32'(err));
    chk({tag, ".wcnt"}, 32'(word_cnt), 32'(wc));
  endtask

  task automatic start(input logic with_byte);
    @(negedge clk);
    ld_start = 1'b1;
    ld_valid = with_byte;
    ld_byte  = 8'hEE;
    @(posedge clk);
    #1;
    ld_start = 1'b0;
    ld_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last,
                      input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    n = 0;
    while (!ld_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ld_ready) begin
      errors++;
      $display("FAIL send_timeout observed=ready0 expected=ready1");
    end
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] pc);
    logic [31:0] e;
    pc2rom = pc;
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, rom_ins, e);
    end
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b1; pc2rom = '0; ld_start = 0;
    ld_valid = 0; ld_byte = '0; ld_last = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: asynchronous reset from LOAD, checked before the next edge
    start(1'b0);
    status("t1_load", 1, 0, 0, 0);
    async_reset();
    status("t1_rst", 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;

    // 2/3: single word with last on 4th byte; NOP while loading
    start(1'b0);
    pc2rom = 32'h0; #1;
    chk("t3_busy_nop", rom_ins, NOP);
    send(8'h13, 0, 0); send(8'h05, 0, 0);
    send(8'h10, 0, 0); send(8'h00, 1, 0);
    status("t2_done", 0, 1, 0, 1);
    exp_q.push_back(32'h0010_0513);
    rd("t2_mem0", 32'h0);
    exp_q.push_back(NOP);
    rd("t3_misalign", 32'h2);
    exp_q.push_back(NOP);
    rd("t3_oob", 32'(4*DEPTH));
    exp_q.push_back(NOP);
    rd("t3_high", 32'h8000_0000);

    // 4: partial last word with random valid gaps
    start(1'b0);
    status("t4_start", 1, 0, 0, 0);
    send(8'hAA, 0, $urandom_range(0, 3));
    exp_q.push_back(32'hDDCC_BBAA);
    send(8'hBB, 0, $urandom_range(0, 3));
    send(8'hCC, 0, $urandom_range(0, 3));
    send(8'hDD, 0, $urandom_range(0, 3));
    exp_q.push_back(32'h0000_2211);
    send(8'h11, 0, $urandom_range(0, 3));
    send(8'h22, 1, $urandom_range(0, 3));
    status("t4_done", 0, 1, 0, 2);
    rd("t4_mem0", 32'h0);
    rd("t4_mem1", 32'h4);
    // bytes while DONE are ignored
    @(negedge clk);
    ld_valid = 1'b1; ld_byte = 8'h77; ld_last = 1'b1;
    repeat (3) @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
    status("t4_ign", 0, 1, 0, 2);
    exp_q.push_back(32'hDDCC_BBAA);
    rd("t4_ign_mem0", 32'h0);

    // 5: overflow; the byte coincident with ld_start is dropped
    start(1'b1);
    for (int w = 0; w < DEPTH; w++)
      exp_q.push_back({8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)});
    for (int i = 1; i <= 16; i++)
      send(8'(i), 0, 0);
    status("t5_full", 1, 0, 0, 4);
    send(8'h11, 0, 0);
    status("t5_ovf", 0, 1, 1, 4);
    for (int w = 0; w < DEPTH; w++)
      rd($sformatf("t5_mem%0d", w), 32'(4*w));

    // 6: ld_start clears sticky flags; reset mid-load keeps written words
    start(1'b0);
    status("t6_clear", 1, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      send(8'h51 + 8'(i), 0, 0);
    chk("t6_wcnt5", 32'(word_cnt), 32'd1);
    async_reset();
    status("t6_rst", 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    exp_q.push_back(32'h5453_5251);
    rd("t6_mem0", 32'h0);
    exp_q.push_back(32'h0807_0605);
    rd("t6_mem1", 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
